// File: rtl/match_ratio_filter.sv
// Ratio-test match filter: scans the match memory, keeps entries whose best distance
// beats the second-best by RATIO_NUM/RATIO_DEN, and streams them out over valid/ready.
module match_ratio_filter #(
   parameter int ADDR_W    = 10,
   parameter int RATIO_NUM = 4,
   parameter int RATIO_DEN = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [ADDR_W:0]   num_tar,
   output logic              mem_rd,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [48:0]       mem_dout,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ADDR_W-1:0] out_tar_idx,
   output logic [18:0]       out_coord,
   output logic [14:0]       out_dist,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W:0]   match_cnt
);

   // Output handshake: an entry transfers on a rising edge where out_valid && out_ready;
   // out_valid, once raised, stays high with out_* frozen until that edge.

   typedef enum logic [2:0] {IDLE, RD, CHK, OUT, FIN} state_t;

   localparam logic [2:0]        NUM3    = 3'(RATIO_NUM);
   localparam logic [2:0]        DEN3    = 3'(RATIO_DEN);
   localparam logic [ADDR_W-1:0] IDX_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
   localparam logic [ADDR_W:0]   CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

   state_t              state, state_nx;
   logic [ADDR_W-1:0]   index, index_nx;
   logic [ADDR_W:0]     num_q;
   logic [17:0]         lhs, rhs;
   logic                hit, is_last, start_ok;

   // 15-bit distance times 3-bit ratio term fits exactly in 18 bits.
   assign lhs      = {3'b000, mem_dout[29:15]} * {15'd0, DEN3};
   assign rhs      = {3'b000, mem_dout[14:0]}  * {15'd0, NUM3};
   assign hit      = (lhs < rhs);
   assign is_last  = ({1'b0, index} == (num_q - CNT_ONE));
   assign start_ok = (state == IDLE) && start;

   always_comb begin
      state_nx = state;
      index_nx = index;
      case (state)
         IDLE: begin
            if (start) begin
               index_nx = '0;
               state_nx = (num_tar == '0) ? FIN : RD;
            end
         end
         RD:  state_nx = CHK;
         CHK: begin
            if (hit) begin
               state_nx = OUT;
            end else if (is_last) begin
               state_nx = FIN;
            end else begin
               index_nx = index + IDX_ONE;
               state_nx = RD;
            end
         end
         OUT: begin
            if (out_ready) begin
               if (is_last) begin
                  state_nx = FIN;
               end else begin
                  index_nx = index + IDX_ONE;
                  state_nx = RD;
               end
            end
         end
         FIN:     state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         index       <= '0;
         num_q       <= '0;
         match_cnt   <= '0;
         mem_rd      <= 1'b0;
         mem_addr    <= '0;
         out_valid   <= 1'b0;
         out_tar_idx <= '0;
         out_coord   <= '0;
         out_dist    <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
      end else begin
         state  <= state_nx;
         index  <= index_nx;
         mem_rd <= (state_nx == RD);
         if (state_nx == RD) begin
            mem_addr <= index_nx;
         end
         done <= (state == FIN);
         // busy falls on the edge after the done pulse begins; a fresh start wins.
         if (start_ok) begin
            num_q     <= num_tar;
            match_cnt <= '0;
            busy      <= 1'b1;
         end else if (done) begin
            busy <= 1'b0;
         end
         if ((state == CHK) && hit) begin
            out_valid   <= 1'b1;
            out_tar_idx <= index;
            out_coord   <= mem_dout[48:30];
            out_dist    <= mem_dout[29:15];
         end
         if ((state == OUT) && out_ready) begin
            out_valid <= 1'b0;
            match_cnt <= match_cnt + CNT_ONE;
         end
      end
   end

endmodule

// File: tb/tb_match_ratio_filter.sv
// Directed bench for match_ratio_filter: single-entry ratio-test table plus
// multi-cycle sequences (empty scan, back-pressure, restart, mid-scan reset, full scan).
module tb_match_ratio_filter;

   localparam int ADDR_W = 10;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              start = 1'b0;
   logic [ADDR_W:0]   num_tar = '0;
   logic              mem_rd;
   logic [ADDR_W-1:0] mem_addr;
   logic [48:0]       mem_dout = '0;
   logic              out_valid;
   logic              out_ready = 1'b1;
   logic [ADDR_W-1:0] out_tar_idx;
   logic [18:0]       out_coord;
   logic [14:0]       out_dist;
   logic              busy;
   logic              done;
   logic [ADDR_W:0]   match_cnt;

   match_ratio_filter #(.ADDR_W(ADDR_W), .RATIO_NUM(4), .RATIO_DEN(5)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .num_tar(num_tar),
      .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_dout(mem_dout),
      .out_valid(out_valid), .out_ready(out_ready), .out_tar_idx(out_tar_idx),
      .out_coord(out_coord), .out_dist(out_dist), .busy(busy), .done(done),
      .match_cnt(match_cnt)
   );

   always #5 clk = ~clk;

   // Match memory: data appears the cycle after the read strobe.
   logic [48:0] mem [1024];
   always @(posedge clk) if (mem_rd) mem_dout <= mem[mem_addr];

   int vectors = 0;
   int miscompares = 0;
   int done_cnt = 0;
   int rd_cnt = 0;
   logic [43:0] exp_q[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Scoreboard: a transfer happens at the next rising edge when valid && ready here.
   always @(negedge clk) begin
      if (rst_n) begin
         if (done) done_cnt++;
         if (mem_rd) rd_cnt++;
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) check("unexpected_out", {out_tar_idx, out_coord, out_dist}, 64'hdead);
            else check("out", {out_tar_idx, out_coord, out_dist}, exp_q.pop_front());
         end
      end
   end

   task automatic start_scan(input int n);
      @(posedge clk); #1;
      num_tar = (ADDR_W+1)'(n);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      num_tar = '1;
   endtask

   task automatic wait_done(input int budget);
      int c = 0;
      while (c < budget) begin
         @(negedge clk);
         if (done) break;
         c++;
      end
      check("done_seen", c < budget, 1);
      @(negedge clk);
      check("done_one_cycle", done, 0);
      check("busy_after_done", busy, 0);
   endtask

   task automatic wait_valid(input int budget);
      int c = 0;
      while (c < budget) begin
         @(negedge clk);
         if (out_valid) break;
         c++;
      end
      check("valid_seen", c < budget, 1);
   endtask

   typedef struct {
      logic [14:0] min;
      logic [14:0] min2;
      logic [18:0] coord;
      logic        acc;
   } vec_t;

   vec_t vecs [12];

   initial begin
      int d0, r0;
      logic [43:0] held;

      // accept iff 5*min < 4*min2
      vecs[0]  = '{min:15'd100,   min2:15'd200,   coord:19'h12345, acc:1'b1};
      vecs[1]  = '{min:15'd160,   min2:15'd200,   coord:19'h00001, acc:1'b0};
      vecs[2]  = '{min:15'd80,    min2:15'd100,   coord:19'h00002, acc:1'b0};
      vecs[3]  = '{min:15'h7FFF,  min2:15'h7FFF,  coord:19'h00003, acc:1'b0};
      vecs[4]  = '{min:15'd0,     min2:15'd1,     coord:19'h7FFFF, acc:1'b1};
      vecs[5]  = '{min:15'd0,     min2:15'd0,     coord:19'h00005, acc:1'b0};
      vecs[6]  = '{min:15'd26213, min2:15'h7FFF,  coord:19'h2AAAA, acc:1'b1};
      vecs[7]  = '{min:15'd26214, min2:15'h7FFF,  coord:19'h00007, acc:1'b0};
      vecs[8]  = '{min:15'd1,     min2:15'd2,     coord:19'h55555, acc:1'b1};
      vecs[9]  = '{min:15'd4,     min2:15'd5,     coord:19'h00009, acc:1'b0};
      vecs[10] = '{min:15'h7FFF,  min2:15'd0,     coord:19'h0000A, acc:1'b0};
      vecs[11] = '{min:15'd3,     min2:15'd4,     coord:19'h3C3C3, acc:1'b1};

      for (int i = 0; i < 1024; i++) mem[i] = '0;

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_out_valid", out_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_mem_rd", mem_rd, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_match_cnt", match_cnt, 0);
      check("rst_out_fields", {out_tar_idx, out_coord, out_dist}, 0);
      rst_n = 1'b1;

      // Single-entry ratio-test table
      for (int i = 0; i < 12; i++) begin
         mem[0] = {vecs[i].coord, vecs[i].min, vecs[i].min2};
         if (vecs[i].acc) exp_q.push_back({10'd0, vecs[i].coord, vecs[i].min});
         start_scan(1);
         wait_done(20);
         check("vec_match_cnt", match_cnt, {10'd0, vecs[i].acc});
         check("vec_q_empty", exp_q.size(), 0);
      end

      // Three entries: only idx0 passes, the others tie exactly
      mem[0] = {19'h11111, 15'd100, 15'd200};
      mem[1] = {19'h22222, 15'd160, 15'd200};
      mem[2] = {19'h33333, 15'd80,  15'd100};
      exp_q.push_back({10'd0, 19'h11111, 15'd100});
      d0 = done_cnt;
      start_scan(3);
      wait_done(30);
      check("three_match_cnt", match_cnt, 1);
      check("three_q_empty", exp_q.size(), 0);
      check("three_done_cnt", done_cnt - d0, 1);

      // Empty scan: done two cycles after start, no reads
      r0 = rd_cnt;
      start_scan(0);
      @(negedge clk);
      check("empty_done_early", done, 0);
      check("empty_busy", busy, 1);
      @(negedge clk);
      check("empty_done", done, 1);
      @(negedge clk);
      check("empty_done_drop", done, 0);
      check("empty_busy_drop", busy, 0);
      check("empty_no_rd", rd_cnt - r0, 0);
      check("empty_match_cnt", match_cnt, 0);

      // Back-pressure on the first of two accepted entries
      mem[0] = {19'h0ABCD, 15'd1, 15'd2};
      mem[1] = {19'h1BEEF, 15'd3, 15'd4};
      exp_q.push_back({10'd0, 19'h0ABCD, 15'd1});
      exp_q.push_back({10'd1, 19'h1BEEF, 15'd3});
      @(posedge clk); #1 out_ready = 1'b0;
      start_scan(2);
      wait_valid(20);
      held = {out_tar_idx, out_coord, out_dist};
      for (int i = 0; i < 5; i++) begin
         check("bp_valid", out_valid, 1);
         check("bp_stable", {out_tar_idx, out_coord, out_dist}, {10'd0, 19'h0ABCD, 15'd1});
         check("bp_hold", {out_tar_idx, out_coord, out_dist}, held);
         @(negedge clk);
      end
      @(posedge clk); #1 out_ready = 1'b1;
      wait_done(30);
      check("bp_match_cnt", match_cnt, 2);
      check("bp_q_empty", exp_q.size(), 0);

      // Start pulsed while busy is ignored
      mem[0] = {19'h11111, 15'd100, 15'd200};
      mem[1] = {19'h22222, 15'd160, 15'd200};
      mem[2] = {19'h33333, 15'd80,  15'd100};
      exp_q.push_back({10'd0, 19'h11111, 15'd100});
      d0 = done_cnt;
      r0 = rd_cnt;
      start_scan(3);
      @(posedge clk); #1 start = 1'b1; num_tar = 11'd5;
      @(posedge clk); #1 start = 1'b0;
      wait_done(30);
      repeat (10) @(negedge clk);
      check("restart_done_cnt", done_cnt - d0, 1);
      check("restart_rd_cnt", rd_cnt - r0, 3);
      check("restart_match_cnt", match_cnt, 1);
      check("restart_busy", busy, 0);
      check("restart_q_empty", exp_q.size(), 0);

      // Reset while holding an output
      mem[0] = {19'h40404, 15'd10, 15'd100};
      mem[1] = {19'h50505, 15'd90, 15'd100};
      exp_q.push_back({10'd0, 19'h40404, 15'd10});
      @(posedge clk); #1 out_ready = 1'b0;
      start_scan(2);
      wait_valid(20);
      d0 = done_cnt;
      #1 rst_n = 1'b0;
      #1;
      check("arst_out_valid", out_valid, 0);
      check("arst_busy", busy, 0);
      check("arst_match_cnt", match_cnt, 0);
      exp_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b1;
      repeat (5) @(negedge clk);
      check("arst_no_done", done_cnt - d0, 0);
      check("arst_idle_busy", busy, 0);
      exp_q.push_back({10'd0, 19'h40404, 15'd10});
      start_scan(2);
      wait_done(30);
      check("arst_rescan_cnt", match_cnt, 1);
      check("arst_q_empty", exp_q.size(), 0);

      // Full-depth scan with every entry accepted
      for (int i = 0; i < 1024; i++) begin
         mem[i] = {19'(i), 15'd0, 15'd1};
         exp_q.push_back({10'(i), 19'(i), 15'd0});
      end
      r0 = rd_cnt;
      start_scan(1024);
      wait_done(4000);
      check("full_match_cnt", match_cnt, 11'd1024);
      check("full_rd_cnt", rd_cnt - r0, 1024);
      check("full_q_empty", exp_q.size(), 0);
      check("full_last_idx", out_tar_idx, 10'd1023);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/match_ratio_filter.md
MATCH_RATIO_FILTER -- requirements
Module: match_ratio_filter

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, width of the target-entry index.
REQ-002 SHALL have parameter RATIO_NUM, default 4, ratio-test numerator (3 bits).
REQ-003 SHALL have parameter RATIO_DEN, default 5, ratio-test denominator (3 bits).
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port start  input  1  one-cycle pulse that begins a scan of the match memory.
REQ-007 SHALL have port num_tar  input  ADDR_W+1  number of target entries to scan, sampled on accepted start.
REQ-008 SHALL have port mem_rd  output  1  match-memory read strobe.
REQ-009 SHALL have port mem_addr  output  ADDR_W  match-memory read address.
REQ-010 SHALL have port mem_dout  input  49  match entry {coord[48:30], min[29:15], min2[14:0]}, valid the cycle after mem_rd.
REQ-011 SHALL have port out_valid  output  1  accepted-match valid.
REQ-012 SHALL have port out_ready  input  1  downstream ready.
REQ-013 SHALL have port out_tar_idx  output  ADDR_W  target index of the accepted match.
REQ-014 SHALL have port out_coord  output  19  image-keypoint row/col of the best match.
REQ-015 SHALL have port out_dist  output  15  best distance (min).
REQ-016 SHALL have port busy  output  1  high from accepted start until done.
REQ-017 SHALL have port done  output  1  one-cycle pulse at scan end.
REQ-018 SHALL have port match_cnt  output  ADDR_W+1  number of matches emitted in the current/last scan.

Function
REQ-019 SHALL implement states IDLE, RD, CHK, OUT, FIN.
REQ-020 SHALL accept start only in IDLE; start in any other state SHALL be ignored.
REQ-021 On accepted start SHALL latch num_tar, clear index and match_cnt, and go to FIN if num_tar==0, else RD.
REQ-022 In RD SHALL assert mem_rd for exactly one cycle with mem_addr=index, then go to CHK.
REQ-023 In CHK SHALL sample mem_dout and accept the entry iff min*RATIO_DEN < min2*RATIO_NUM, both products unsigned 18-bit, no truncation, strict less-than.
REQ-024 On accept SHALL register index, coord, min onto out_tar_idx/out_coord/out_dist and go to OUT.
REQ-025 On reject SHALL go to FIN if index==num_tar-1, else increment index and go to RD.
REQ-026 In OUT SHALL hold out_valid=1 with out_* stable until the cycle out_valid&&out_ready.
REQ-027 On that handshake SHALL increment match_cnt, drop out_valid next cycle, and go to FIN if last entry, else increment index and go to RD.
REQ-028 out_ready while out_valid==0 SHALL have no effect.
REQ-029 In FIN SHALL pulse done for one cycle, deassert busy on the following edge, and return to IDLE.
REQ-030 Per-entry latency SHALL be 2 cycles for reject, 3 cycles plus back-pressure for accept.
REQ-031 An entry with min=min2=15'h7FFF (never updated) SHALL be rejected by REQ-023 without special-casing.
REQ-032 match_cnt SHALL hold its value after done until the next accepted start.
REQ-033 mem_addr SHALL hold its last value when mem_rd==0.

Reset
REQ-034 rst_n low SHALL immediately force IDLE and clear index, match_cnt, mem_rd, mem_addr, out_valid, out_tar_idx, out_coord, out_dist, busy, done to 0.
REQ-035 Reset asserted mid-scan (including in OUT with out_valid high) SHALL abandon the scan with no done pulse; the first cycle after release SHALL be IDLE.

Verification
REQ-036 num_tar=3, entries {min=100,min2=200},{min=160,min2=200},{min=80,min2=100}, out_ready=1 -> one output idx0 dist100; idx1 rejected (800 !< 800); idx2 rejected (400 !< 400); done, match_cnt=1.
REQ-037 num_tar=0, start -> done pulses 2 cycles after start, no mem_rd, match_cnt=0.
REQ-038 num_tar=2, both accepted, out_ready low 5 cycles on first -> out_valid and out_* stable 5 cycles, both emitted in order, match_cnt=2.
REQ-039 start pulsed again while busy -> ignored, scan completes unchanged, single done.
REQ-040 rst_n asserted in OUT -> out_valid=0 asynchronously, no done, next start scans from idx0 with match_cnt=0.
REQ-041 num_tar=1024 (ADDR_W=10), all entries min=0,min2=1 -> 1024 outputs, last idx 1023, index no wrap before FIN, match_cnt=1024.
